// File: rtl/dm_access_ctrl_if.sv
// Bus bundle between the CPU memory stage, dm_access_ctrl and the word-wide data memory.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 10
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              misalign;
    logic [ADDR_W-1:0] dm_address;
    logic [31:0]       dm_data;
    logic              dm_wren;
    logic [31:0]       dm_q;

    // master is the environment (CPU stage plus memory); slave is the controller
    modport master (
        output req, we, size, sign_ext, addr, wdata, dm_q,
        input  rdata, busy, done, misalign, dm_address, dm_data, dm_wren
    );
    modport slave (
        input  req, we, size, sign_ext, addr, wdata, dm_q,
        output rdata, busy, done, misalign, dm_address, dm_data, dm_wren
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer over a word-only data memory: sub-word stores as
// read-modify-write, load lane extraction with sign/zero extension, misalign rejection.
module dm_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    dm_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        boff_q;
    logic [15:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] waddr_q;

    logic              accept;
    logic              misaligned;
    logic              word_store;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    assign accept     = (state_q == S_IDLE) && bus.req;
    assign misaligned = (bus.size == 2'b11)
                     || (bus.size == 2'b01 && bus.addr[0])
                     || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    assign word_store = bus.we && (bus.size == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.misalign = 1'b0;
        bus.dm_wren  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (misaligned)      state_d = S_ERR;
                    else if (word_store) state_d = S_WR;
                    else                 state_d = S_RD;
                end
            end
            S_RD: begin
                bus.busy = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                state_d  = we_q ? S_WR : S_DONE;
            end
            S_WR: begin
                bus.busy = 1'b1;
                // gated with rst so a reset landing on WR never commits the write
                bus.dm_wren = !rst;
                state_d  = S_DONE;
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                bus.misalign = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane extraction for loads; dm_q is valid in WAIT
    always_comb begin
        case (boff_q)
            2'd0:    lane_b = bus.dm_q[7:0];
            2'd1:    lane_b = bus.dm_q[15:8];
            2'd2:    lane_b = bus.dm_q[23:16];
            default: lane_b = bus.dm_q[31:24];
        endcase
        lane_h = boff_q[1] ? bus.dm_q[31:16] : bus.dm_q[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
            default: load_val = bus.dm_q;
        endcase
    end

    // Read-modify-write merge for sub-word stores
    always_comb begin
        merged = bus.dm_q;
        if (size_q == 2'b00) begin
            case (boff_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (boff_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // data_q doubles as the merge register and the memory write-data driver
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            boff_q  <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            data_q  <= '0;
            waddr_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                size_q  <= bus.size;
                sext_q  <= bus.sign_ext;
                boff_q  <= bus.addr[1:0];
                wdata_q <= bus.wdata[15:0];
                if (!misaligned) begin
                    waddr_q <= bus.addr[ADDR_W+1:2];
                    if (word_store) data_q <= bus.wdata;
                end
            end
            if (state_q == S_WAIT) begin
                if (we_q) data_q  <= merged;
                else      rdata_q <= load_val;
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.dm_address = waddr_q;
    assign bus.dm_data    = data_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a registered-read word memory model.
module tb_dm_access_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    dm_access_ctrl_if #(.ADDR_W(10)) bus ();

    dm_access_ctrl #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic        pk_en = 1'b0;
    logic [9:0]  pk_a  = '0;
    logic [31:0] pk_d  = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        if (bus.dm_wren) begin
            mem[bus.dm_address] <= bus.dm_data;
            wr_count <= wr_count + 1;
        end
        bus.dm_q <= mem[bus.dm_address];
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // Issue one request from IDLE; lat is the edge at which done is sampled (-1 on timeout)
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic mis, output int wrs, output logic busy_ok);
        int w0;
        w0 = wr_count;
        busy_ok = 1'b1;
        mis = 1'b0;
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            if (lat < 0) begin
                if (!bus.busy) busy_ok = 1'b0;
                if (bus.done) begin
                    lat = k;
                    mis = bus.misalign;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
        wrs = wr_count - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        n_cmp++; if (bus.dm_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b want 0", bus.dm_wren); end
        n_cmp++; if (bus.dm_address !== 10'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.dm_address); end
        n_cmp++; if (bus.dm_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.dm_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store_load();
        int lat, wrs; logic mis, bok;
        run_op(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, lat, mis, wrs, bok);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_cmp++; if (wrs != 1) begin n_err++; $display("FAIL sw_wren_pulses: got %0d want 1", wrs); end
        n_cmp++; if (bus.dm_address !== 10'h004) begin n_err++; $display("FAIL sw_address: got %h want 004", bus.dm_address); end
        n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
        n_cmp++; if (!bok || mis) begin n_err++; $display("FAIL sw_busy_mis: got busy_ok=%b mis=%b want 1/0", bok, mis); end
        run_op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL lw_latency: got %0d want 3", lat); end
        n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %h want deadbeef", bus.rdata); end
        n_cmp++; if (wrs != 0) begin n_err++; $display("FAIL lw_wren_pulses: got %0d want 0", wrs); end
    endtask

    task automatic test_subword_store();
        int lat, wrs; logic mis, bok;
        poke(10'h008, 32'h11223344);
        run_op(1'b1, 2'b00, 1'b0, 32'h022, 32'h000000AB, lat, mis, wrs, bok);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL sb_latency: got %0d want 4", lat); end
        n_cmp++; if (wrs != 1) begin n_err++; $display("FAIL sb_wren_pulses: got %0d want 1", wrs); end
        n_cmp++; if (bus.dm_data !== 32'h11AB3344) begin n_err++; $display("FAIL sb_dm_data: got %h want 11ab3344", bus.dm_data); end
        run_op(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'h11AB3344) begin n_err++; $display("FAIL sb_readback: got %h want 11ab3344", bus.rdata); end
        run_op(1'b1, 2'b01, 1'b0, 32'h022, 32'h1234BEEF, lat, mis, wrs, bok);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL sh_latency: got %0d want 4", lat); end
        n_cmp++; if (mem[8] !== 32'hBEEF3344) begin n_err++; $display("FAIL sh_mem: got %h want beef3344", mem[8]); end
    endtask

    task automatic test_loads();
        int lat, wrs; logic mis, bok;
        poke(10'h00C, 32'h80FF7F01);
        run_op(1'b0, 2'b00, 1'b1, 32'h032, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'hFFFFFFFF) begin n_err++; $display("FAIL lb_032: got %h want ffffffff", bus.rdata); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL lb_latency: got %0d want 3", lat); end
        run_op(1'b0, 2'b00, 1'b0, 32'h032, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'h000000FF) begin n_err++; $display("FAIL lbu_032: got %h want 000000ff", bus.rdata); end
        run_op(1'b0, 2'b00, 1'b1, 32'h031, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'h0000007F) begin n_err++; $display("FAIL lb_031: got %h want 0000007f", bus.rdata); end
        run_op(1'b0, 2'b00, 1'b1, 32'h033, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_033: got %h want ffffff80", bus.rdata); end
        run_op(1'b0, 2'b01, 1'b1, 32'h032, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh_032: got %h want ffff80ff", bus.rdata); end
        run_op(1'b0, 2'b01, 1'b0, 32'h030, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (bus.rdata !== 32'h00007F01) begin n_err++; $display("FAIL lhu_030: got %h want 00007f01", bus.rdata); end
    endtask

    task automatic test_misalign();
        int lat, wrs; logic mis, bok;
        run_op(1'b0, 2'b01, 1'b1, 32'h041, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (lat != 1 || mis !== 1'b1) begin n_err++; $display("FAIL mis_lh: got lat=%0d mis=%b want 1/1", lat, mis); end
        n_cmp++; if (bus.rdata !== 32'h00007F01) begin n_err++; $display("FAIL mis_rdata: got %h want 00007f01", bus.rdata); end
        run_op(1'b1, 2'b10, 1'b0, 32'h042, 32'h12345678, lat, mis, wrs, bok);
        n_cmp++; if (lat != 1 || mis !== 1'b1) begin n_err++; $display("FAIL mis_sw: got lat=%0d mis=%b want 1/1", lat, mis); end
        n_cmp++; if (wrs != 0) begin n_err++; $display("FAIL mis_sw_wren: got %0d want 0", wrs); end
        run_op(1'b0, 2'b11, 1'b0, 32'h040, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (lat != 1 || mis !== 1'b1) begin n_err++; $display("FAIL mis_size11: got lat=%0d mis=%b want 1/1", lat, mis); end
        run_op(1'b0, 2'b10, 1'b0, 32'h030, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL aligned_no_mis: got %b want 0", mis); end
    endtask

    task automatic test_reset_mid_store();
        int lat, wrs, w0; logic mis, bok, seen_done;
        poke(10'h014, 32'hCAFEF00D);
        w0 = wr_count;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b01; bus.sign_ext = 1'b0;
        bus.addr = 32'h050; bus.wdata = 32'h00005555;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.dm_wren !== 1'b0) begin n_err++; $display("FAIL rst_wr_wren: got %b want 0", bus.dm_wren); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_wr_busy: got %b want 0", bus.busy); end
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_done) begin n_err++; $display("FAIL rst_wr_done: got done pulse want none"); end
        n_cmp++; if (wr_count != w0 || mem[20] !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL rst_wr_mem: got %h writes=%0d want cafef00d writes=0", mem[20], wr_count - w0);
        end
        // rst together with req: the request is dropped
        rst = 1'b1; bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h050;
        @(posedge clk); #1;
        rst = 1'b0; bus.req = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_req_busy: got %b want 0", bus.busy); end
        run_op(1'b0, 2'b10, 1'b0, 32'h050, 32'h0, lat, mis, wrs, bok);
        n_cmp++; if (lat != 3 || bus.rdata !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL rst_after_lw: got lat=%0d rdata=%h want 3/cafef00d", lat, bus.rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] busy_m, done_m;
        int n, w0;
        busy_m = '0; done_m = '0; n = 0;
        w0 = wr_count;
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 32'h060; bus.wdata = 32'hA0A0A0A0;
        for (int c = 0; c <= 8; c++) begin
            busy_m[c] = bus.busy;
            done_m[c] = bus.done;
            if (bus.done) begin
                n++;
                bus.addr  = 32'h060 + 32'(4 * n);
                bus.wdata = 32'hA0A0A0A0 + 32'(n);
                if (n == 3) bus.req = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        n_cmp++; if (done_m !== 9'b100100100) begin n_err++; $display("FAIL b2b_done: got %b want 100100100", done_m); end
        n_cmp++; if (busy_m !== 9'b110110110) begin n_err++; $display("FAIL b2b_busy: got %b want 110110110", busy_m); end
        n_cmp++; if (wr_count - w0 != 3) begin n_err++; $display("FAIL b2b_writes: got %0d want 3", wr_count - w0); end
        n_cmp++; if (mem[24] !== 32'hA0A0A0A0 || mem[25] !== 32'hA0A0A0A1 || mem[26] !== 32'hA0A0A0A2) begin
            n_err++; $display("FAIL b2b_mem: got %h %h %h want a0a0a0a0 a0a0a0a1 a0a0a0a2", mem[24], mem[25], mem[26]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_loads();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
